// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle FSM and the 16-bit datapath.
// master = control unit, slave = datapath side.
interface mc_ctrl_fsm_if #(
  parameter int ST_W = 4
);
  logic [3:0]      opcode;
  logic            zero;
  logic            mem_ready;
  logic            pc_en;
  logic            ir_en;
  logic            a_en;
  logic            b_en;
  logic            aluout_en;
  logic            mdr_en;
  logic            rf_we;
  logic            mem_rd;
  logic            mem_wr;
  logic            iord;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_src;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            halted;
  logic            illegal_op;
  logic [ST_W-1:0] dbg_state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_en, a_en, b_en,
    output aluout_en, mdr_en, rf_we,
    output mem_rd, mem_wr, iord,
    output alu_src_a, alu_src_b, alu_op,
    output pc_src, reg_dst, mem_to_reg,
    output halted, illegal_op, dbg_state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_en, a_en, b_en,
    input  aluout_en, mdr_en, rf_we,
    input  mem_rd, mem_wr, iord,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_src, reg_dst, mem_to_reg,
    input  halted, illegal_op, dbg_state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit RISC datapath.
// Define MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR on mem_ready.
module mc_ctrl_fsm #(
  parameter int ST_W = 4
) (
  input logic        clk,
  input logic        CLR,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_EXEC_R = ST_W'(2);
  localparam logic [ST_W-1:0] S_EXEC_I = ST_W'(3);
  localparam logic [ST_W-1:0] S_ALU_WB = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEM_RD = ST_W'(5);
  localparam logic [ST_W-1:0] S_MEM_WB = ST_W'(6);
  localparam logic [ST_W-1:0] S_MEM_WR = ST_W'(7);
  localparam logic [ST_W-1:0] S_BRANCH = ST_W'(8);
  localparam logic [ST_W-1:0] S_JUMP   = ST_W'(9);
  localparam logic [ST_W-1:0] S_HALT   = ST_W'(10);

  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [3:0]      op;
  logic            rdy;
  logic            is_r;
  logic            is_i;
  logic            is_beq;
  logic            is_jmp;
  logic            is_hlt;
  logic            is_ill;

  assign op = bus.opcode;

`ifdef MEM_WAIT_EN
  assign rdy = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign rdy = 1'b1;
`endif

  assign is_r   = (op >= 4'h1) && (op <= 4'h4);
  assign is_i   = (op >= OP_ADDI) && (op <= OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_jmp = (op == OP_JMP);
  assign is_hlt = (op == OP_HLT);
  assign is_ill = (op >= 4'hA) && (op <= 4'hE);

  assign bus.dbg_state = state;

  // State register; CLR restarts at FETCH.
  always_ff @(posedge clk) begin
    if (CLR) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state sequencing from opcode and memory handshake.
  always_comb begin
    state_nxt = S_FETCH;
    unique case (state)
      S_FETCH:  state_nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_nxt = S_EXEC_R;
          is_i:    state_nxt = S_EXEC_I;
          is_beq:  state_nxt = S_BRANCH;
          is_jmp:  state_nxt = S_JUMP;
          is_hlt:  state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R: state_nxt = S_ALU_WB;
      S_EXEC_I: begin
        if (op == OP_LW)      state_nxt = S_MEM_RD;
        else if (op == OP_SW) state_nxt = S_MEM_WR;
        else                  state_nxt = S_ALU_WB;
      end
      S_ALU_WB: state_nxt = S_FETCH;
      S_MEM_RD: state_nxt = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: state_nxt = S_FETCH;
      S_MEM_WR: state_nxt = rdy ? S_FETCH : S_MEM_WR;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Datapath controls; everything held low while CLR is high.
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.ir_en      = 1'b0;
    bus.a_en       = 1'b0;
    bus.b_en       = 1'b0;
    bus.aluout_en  = 1'b0;
    bus.mdr_en     = 1'b0;
    bus.rf_we      = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.iord       = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = 2'd0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.halted     = 1'b0;
    bus.illegal_op = 1'b0;
    if (!CLR) begin
      unique case (state)
        S_FETCH: begin
          bus.mem_rd    = 1'b1;
          bus.ir_en     = rdy;
          bus.pc_en     = rdy;
          bus.alu_src_b = 2'd1;
        end
        S_DECODE: begin
          bus.a_en       = 1'b1;
          bus.b_en       = 1'b1;
          bus.aluout_en  = 1'b1;
          bus.alu_src_b  = 2'd2;
          bus.illegal_op = is_ill;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'(op - 4'd1);
          bus.aluout_en = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
          bus.aluout_en = 1'b1;
        end
        S_ALU_WB: begin
          bus.rf_we   = 1'b1;
          bus.reg_dst = is_r;
        end
        S_MEM_RD: begin
          bus.mem_rd = 1'b1;
          bus.iord   = 1'b1;
          bus.mdr_en = rdy;
        end
        S_MEM_WB: begin
          bus.rf_we      = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_wr = 1'b1;
          bus.iord   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = 2'd1;
          bus.pc_en     = bus.zero;
        end
        S_JUMP: begin
          bus.pc_src = 2'd2;
          bus.pc_en  = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm.
// Expected controls come from a per-instruction phase model.
module tb_mc_ctrl_fsm;

`ifdef MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  localparam int B_PC    = 20;
  localparam int B_IR    = 19;
  localparam int B_A     = 18;
  localparam int B_B     = 17;
  localparam int B_AO    = 16;
  localparam int B_MDR   = 15;
  localparam int B_RFWE  = 14;
  localparam int B_MRD   = 13;
  localparam int B_MWR   = 12;
  localparam int B_ILL   = 11;
  localparam int B_HALT  = 10;
  localparam int B_IORD  = 9;
  localparam int B_SRCA  = 8;
  localparam int B_SRCB  = 6;
  localparam int B_OP    = 4;
  localparam int B_PCSRC = 2;
  localparam int B_RDST  = 1;
  localparam int B_MTR   = 0;

  typedef enum int {
    P_CLR, P_F, P_D, P_XR, P_XI, P_WB,
    P_MR, P_MWB, P_MW, P_BR, P_J, P_H
  } ph_t;

  typedef struct {
    ph_t         ph;
    logic [20:0] val;
    logic [20:0] care;
  } exp_t;

  logic clk;
  logic clr;
  mc_ctrl_fsm_if #(.ST_W(4)) bus ();

  mc_ctrl_fsm #(.ST_W(4)) dut (
    .clk(clk),
    .CLR(clr),
    .bus(bus)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t put(exp_t e, int lsb, int v);
    e.val = e.val | (21'(v) << lsb);
    return e;
  endfunction

  function automatic exp_t sel(exp_t e, int lsb, int w, int v);
    e.val  = e.val | (21'(v) << lsb);
    e.care = e.care | (21'((1 << w) - 1) << lsb);
    return e;
  endfunction

  // Expected controls for one cycle of a given instruction phase.
  function automatic exp_t exp_for(ph_t ph, logic [3:0] op,
                                   logic z, logic rdy);
    exp_t e;
    bit   go;
    go     = rdy || !WAIT;
    e.ph   = ph;
    e.val  = '0;
    e.care = 21'h1FFC00;
    case (ph)
      P_F: begin
        e = put(e, B_MRD, 1);
        if (go) begin
          e = put(e, B_IR, 1);
          e = put(e, B_PC, 1);
        end
        e = sel(e, B_IORD, 1, 0);
        e = sel(e, B_SRCA, 1, 0);
        e = sel(e, B_SRCB, 2, 1);
        e = sel(e, B_OP, 2, 0);
        e = sel(e, B_PCSRC, 2, 0);
      end
      P_D: begin
        e = put(e, B_A, 1);
        e = put(e, B_B, 1);
        e = put(e, B_AO, 1);
        e = sel(e, B_SRCA, 1, 0);
        e = sel(e, B_SRCB, 2, 2);
        if (op >= 4'hA && op <= 4'hE) e = put(e, B_ILL, 1);
      end
      P_XR: begin
        e = put(e, B_AO, 1);
        e = sel(e, B_SRCA, 1, 1);
        e = sel(e, B_SRCB, 2, 0);
        e = sel(e, B_OP, 2, int'(op) - 1);
      end
      P_XI: begin
        e = put(e, B_AO, 1);
        e = sel(e, B_SRCA, 1, 1);
        e = sel(e, B_SRCB, 2, 2);
        e = sel(e, B_OP, 2, 0);
      end
      P_WB: begin
        e = put(e, B_RFWE, 1);
        e = sel(e, B_MTR, 1, 0);
        e = sel(e, B_RDST, 1, (op >= 4'h1 && op <= 4'h4) ? 1 : 0);
      end
      P_MR: begin
        e = put(e, B_MRD, 1);
        if (go) e = put(e, B_MDR, 1);
        e = sel(e, B_IORD, 1, 1);
      end
      P_MWB: begin
        e = put(e, B_RFWE, 1);
        e = sel(e, B_MTR, 1, 1);
        e = sel(e, B_RDST, 1, 0);
      end
      P_MW: begin
        e = put(e, B_MWR, 1);
        e = sel(e, B_IORD, 1, 1);
      end
      P_BR: begin
        if (z) e = put(e, B_PC, 1);
        e = sel(e, B_SRCA, 1, 1);
        e = sel(e, B_SRCB, 2, 0);
        e = sel(e, B_OP, 2, 1);
        e = sel(e, B_PCSRC, 2, 1);
      end
      P_J: begin
        e = put(e, B_PC, 1);
        e = sel(e, B_PCSRC, 2, 2);
      end
      P_H:     e = put(e, B_HALT, 1);
      default: ;
    endcase
    return e;
  endfunction

  // Phase list of one instruction, FETCH through last phase.
  task automatic plan(input logic [3:0] op, output int n,
                      output ph_t s[6]);
    s = '{default: P_F};
    s[1] = P_D;
    n = 2;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        s[2] = P_XR; s[3] = P_WB; n = 4;
      end
      4'h5: begin s[2] = P_XI; s[3] = P_WB; n = 4; end
      4'h6: begin
        s[2] = P_XI; s[3] = P_MR; s[4] = P_MWB; n = 5;
      end
      4'h7: begin s[2] = P_XI; s[3] = P_MW; n = 4; end
      4'h8: begin s[2] = P_BR; n = 3; end
      4'h9: begin s[2] = P_J; n = 3; end
      default: n = 2;
    endcase
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z,
                           input bit may_abort);
    ph_t s[6];
    int  n;
    int  i;
    int  ab;
    bit  aborted;
    plan(op, n, s);
    ab = -1;
    if (may_abort && ($urandom % 8 == 0)) ab = int'($urandom % n);
    aborted = 0;
    i = 0;
    while (i < n) begin
      @(posedge clk);
      #1;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = 1'($urandom % 2);
      clr           = (i == ab);
      if (clr) begin
        q.push_back(exp_for(P_CLR, op, z, 1'b1));
        aborted = 1;
        i = n;
      end else begin
        q.push_back(exp_for(s[i], op, z, bus.mem_ready));
        if (!(WAIT && !bus.mem_ready &&
              (s[i] == P_F || s[i] == P_MR || s[i] == P_MW)))
          i++;
      end
    end
    if (op == 4'hF && !aborted) begin
      repeat (20) begin
        @(posedge clk);
        #1;
        bus.zero      = 1'($urandom % 2);
        bus.mem_ready = 1'($urandom % 2);
        q.push_back(exp_for(P_H, op, z, 1'b1));
      end
      repeat (2) begin
        @(posedge clk);
        #1;
        clr = 1'b1;
        q.push_back(exp_for(P_CLR, op, z, 1'b1));
      end
    end
  endtask

  // Monitor: pop one expectation per cycle and compare.
  always @(negedge clk) begin
    exp_t        e;
    logic [20:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.pc_en, bus.ir_en, bus.a_en, bus.b_en,
             bus.aluout_en, bus.mdr_en, bus.rf_we,
             bus.mem_rd, bus.mem_wr, bus.illegal_op,
             bus.halted, bus.iord, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.pc_src,
             bus.reg_dst, bus.mem_to_reg};
      n_cmp++;
      if (((act ^ e.val) & e.care) != 21'd0) begin
        n_bad++;
        $display("FAIL ctrl ph=%0s t=%0t got %h want %h care %h",
                 e.ph.name(), $time, act, e.val, e.care);
      end
      n_cmp++;
      if (int'(bus.pc_en) + int'(bus.rf_we) + int'(bus.mem_wr) > 1) begin
        n_bad++;
        $display("FAIL excl t=%0t got pc_en=%0b rf_we=%0b mem_wr=%0b want at most one",
                 $time, bus.pc_en, bus.rf_we, bus.mem_wr);
      end
    end else if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout got no summary want finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr           = 1'b1;
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      clr = 1'b1;
      q.push_back(exp_for(P_CLR, 4'h0, 1'b0, 1'b1));
    end
    run_instr(4'h1, 1'b0, 0);
    run_instr(4'h6, 1'b0, 0);
    run_instr(4'h7, 1'b0, 0);
    run_instr(4'h8, 1'b1, 0);
    run_instr(4'h8, 1'b0, 0);
    run_instr(4'hB, 1'b0, 0);
    run_instr(4'hF, 1'b0, 0);
    run_instr(4'h2, 1'b0, 0);
    run_instr(4'h4, 1'b0, 0);
    run_instr(4'h5, 1'b0, 0);
    run_instr(4'h9, 1'b0, 0);
    run_instr(4'h0, 1'b0, 0);
    repeat (300)
      run_instr(4'($urandom % 16), 1'($urandom % 2), 1);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    done = 1;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the 16-bit RISC datapath.
- Sequences the clock-enabled 16-bit pipeline registers (PC, IR, A, B, ALUOut, MDR), register-file write, memory strobes and datapath mux selects from IR[15:12] and the ALU zero flag.
- One Moore state register; a few outputs are additionally qualified by inputs (Mealy), as noted under Behaviour.

Parameters:
- ST_W, 4, width of the state register and of the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN).
- pc_en, ir_en, a_en, b_en, aluout_en, mdr_en  out  1 each  clk_en for the datapath registers.
- rf_we  out  1  register-file write enable.
- mem_rd, mem_wr  out  1 each  memory strobes.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- alu_src_a  out  1  ALU A input: 0=PC, 1=A.
- alu_src_b  out  2  ALU B input: 0=B, 1=const 1, 2=sign-extended imm.
- alu_op  out  2  0=ADD, 1=SUB, 2=AND, 3=OR.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- reg_dst, mem_to_reg  out  1 each  write-back selects.
- halted  out  1  high in the HALT state.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- dbg_state  out  ST_W  current state encoding.

Behaviour:
- Reset: CLR is sampled on the rising edge of clk; next state is FETCH. While CLR is high, every enable, strobe and pulse output is forced to 0 combinationally. Selects are don't-care (drive 0). halted=0.
- Opcode map:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 ADDI; 6 LW; 7 SW; 8 BEQ; 9 JMP; F HLT.
  - A–E are illegal.
- States and their asserted outputs:
  - FETCH: mem_rd=1, iord=0, ir_en=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0, pc_en=1. Next: DECODE.
  - DECODE: a_en=1, b_en=1; aluout_en=1 with alu_src_a=0, alu_src_b=2 (branch target precompute).
    - ADD/SUB/AND/OR go to EXEC_R; ADDI, LW and SW go to EXEC_I; BEQ goes to BRANCH; JMP goes to JUMP.
    - NOP goes to FETCH; HLT goes to HALT.
    - Illegal opcodes go to FETCH with illegal_op=1 for this one cycle.
  - EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=opcode-1, aluout_en=1. Next: ALU_WB.
  - EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD, aluout_en=1. Next: ALU_WB for ADDI, MEM_RD for LW, MEM_WR for SW.
  - ALU_WB: rf_we=1, mem_to_reg=0, reg_dst=1 for R-type, 0 for ADDI. Next: FETCH.
  - MEM_RD: mem_rd=1, iord=1, mdr_en=1. Next: MEM_WB.
  - MEM_WB: rf_we=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEM_WR: mem_wr=1, iord=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_en=zero (Mealy). Next: FETCH.
  - JUMP: pc_src=2, pc_en=1. Next: FETCH.
  - HALT: halted=1, all enables 0. Stays in HALT until CLR.
- Unused state encodings return to FETCH on the next edge, with no enables asserted in that cycle.
- Latency, FETCH to next FETCH:
  - NOP and illegal opcodes: 2 cycles.
  - BEQ and JMP: 3 cycles.
  - R-type, ADDI and SW: 4 cycles.
  - LW: 5 cycles.
- No two of pc_en, rf_we, mem_wr are ever high in the same cycle, except pc_en with ir_en in FETCH.
- CLR mid-instruction aborts the instruction with no rf_we or mem_wr in the CLR cycle.

Optional Feature:
- MEM_WAIT_EN defined:
  - FETCH, MEM_RD and MEM_WR hold their state until mem_ready=1.
  - In FETCH, ir_en and pc_en are asserted only in the cycle where mem_ready=1.
  - In MEM_RD, mdr_en is likewise qualified by mem_ready.
  - mem_rd and mem_wr stay high for every wait cycle.
- MEM_WAIT_EN undefined:
  - Memory is single-cycle and mem_ready is ignored.
  - Latencies are exactly as listed under Behaviour.

Test Plan:
- CLR=1 for 2 cycles, then 0 → dbg_state=FETCH, all enables 0 during CLR; the first cycle after release shows mem_rd=ir_en=pc_en=1.
- opcode=1 (ADD) → sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH; alu_op=0 in EXEC_R; rf_we=1 with reg_dst=1 in cycle 4 only.
- opcode=6 (LW), then 7 (SW) → LW takes 5 cycles with mdr_en in MEM_RD and mem_to_reg=1 in MEM_WB; SW takes 4 cycles with mem_wr=1, iord=1 in cycle 4.
- opcode=8 with zero=1, then zero=0 → pc_en=1 with pc_src=1 in BRANCH for zero=1; pc_en=0 for zero=0; 3 cycles each.
- opcode=0xB, then 0xF → illegal_op pulses for 1 cycle in DECODE, then FETCH; HLT gives halted=1 held for 20 cycles until CLR.
- MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH → state holds 3 cycles with mem_rd=1 and ir_en=pc_en=0; both pulse once when mem_ready=1.
